color_encoder: RTL and testbench
================================

COLOR_ENCODER -- requirements
Module: color_encoder

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4 (legal range 2..15): consecutive identical synchronized samples required to accept a pin pattern.
REQ-002 SHALL have port Clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port Reset_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port Pins  input  4  asynchronous external color lines; the input side of the Pins-to-Color mapping.
REQ-005 SHALL have port ModeSwitch  input  1  asynchronous mode button; each rising edge toggles Mode.
REQ-006 SHALL have port Ready  input  1  downstream accepts Color when high with Valid.
REQ-007 SHALL have port Color  output  4  encoded color code; upper 2 bits zero in Mode 0.
REQ-008 SHALL have port Valid  output  1  Color holds a new, unconsumed code.
REQ-009 SHALL have port Mode  output  1  0 = one-hot encode, 1 = binary pass-through.
REQ-010 SHALL have port Error  output  1  one-cycle pulse: illegal pattern accepted in Mode 0.

Function
REQ-011 SHALL pass Pins and ModeSwitch each through a 2-flop synchronizer; S denotes the synchronized Pins.
REQ-012 SHALL toggle Mode on each clock where synchronized ModeSwitch is 1 and was 0 the previous clock; holding the button high SHALL NOT toggle again.
REQ-013 SHALL implement states IDLE, SETTLE, HOLD.
REQ-014 IDLE: when S differs from the last-accepted pattern L, SHALL load candidate P=S, clear counter, go to SETTLE.
REQ-015 SETTLE: when S==P, SHALL increment counter; when S!=P, SHALL load P=S and clear counter; when S==L, SHALL return to IDLE.
REQ-016 Accept SHALL occur at the edge where P has been sampled on S for STABLE_CYCLES consecutive edges; on accept, L SHALL load P.
REQ-017 Mode 0 accept mapping: 0001->0, 0010->1, 0100->2, 1000->3: SHALL load Color, assert Valid, go to HOLD.
REQ-018 Mode 0 accept of 0000 (release): SHALL NOT assert Valid or Error; SHALL return to IDLE.
REQ-019 Mode 0 accept of any other pattern: SHALL pulse Error for exactly one cycle, leave Color unchanged, keep Valid low, return to IDLE.
REQ-020 Mode 1 accept: SHALL load Color=P (any of 16 values), assert Valid, go to HOLD.
REQ-021 HOLD: Color and Valid SHALL remain stable until an edge with Ready=1, after which Valid=0 and state IDLE; the pattern transfers on that edge only.
REQ-022 Pin activity during HOLD SHALL NOT be accepted and SHALL NOT overwrite Color; it is evaluated against L once back in IDLE.
REQ-023 Latency: Pins change sampled at edge n and stable thereafter -> Valid high after edge n+1+STABLE_CYCLES.
REQ-024 Mode toggle SHALL set L=0000, clear counter, and move SETTLE->IDLE; a pending HOLD (Color, Valid) SHALL be unaffected.
REQ-025 Toggle and accept on the same edge: the accept SHALL be discarded and the toggle applied.
REQ-026 Ready while Valid=0 SHALL have no effect.

Reset
REQ-027 Reset_n=0 SHALL immediately force Color=0000, Valid=0, Mode=0, Error=0, state IDLE, L=0000, P=0000, counter=0, all synchronizer flops 0.
REQ-028 Reset deassertion SHALL be synchronized to Clk (two-stage release) so that no state changes on the release edge.
REQ-029 Reset asserted mid-SETTLE or mid-HOLD SHALL discard the candidate and pending code without emitting Valid or Error.

Verification
REQ-030 Mode 0, Pins=0100 held 10 clocks, Ready=1 -> Valid high for one cycle after edge 6 from first sample, Color=0010, Error never high.
REQ-031 Mode 0, Pins=0110 held 10 clocks -> single one-cycle Error pulse, Valid stays 0, Color unchanged.
REQ-032 Pins toggles 0001/0000 every 2 clocks for 20 clocks (STABLE_CYCLES=4) -> no Valid, no Error; then 0001 held -> exactly one Valid with Color=0000.
REQ-033 Mode 1 (one ModeSwitch pulse), Pins=1011, Ready=0 for 8 clocks then 1 -> Color=1011, Valid held 8+ cycles, drops after Ready edge; Pins changed to 0101 during hold yields second Valid with 0101 afterward.
REQ-034 ModeSwitch held high 20 clocks -> Mode toggles exactly once; pending Valid preserved.
REQ-035 Reset_n pulsed low during HOLD with Color=0011 -> Color=0000, Valid=0, Mode=0 immediately, no Valid until pins re-settle.

Source files
------------

// File: rtl/color_encoder.sv
// Debounced 4-line color encoder: one-hot to index in mode 0, raw pass-through in mode 1,
// with a ready/valid hold stage, a synchronized mode button and a synchronized reset release.
module color_encoder #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [3:0] Pins,
  input  logic       ModeSwitch,
  input  logic       Ready,
  output logic [3:0] Color,
  output logic       Valid,
  output logic       Mode,
  output logic       Error
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] HOLD   = 2'd2;

  // The IDLE edge that loads the candidate is the first stable sample.
  localparam logic [3:0] ACCEPT_COUNT = 4'(STABLE_CYCLES - 2);

  logic       rst_meta_reg;
  logic       rst_sync_reg;
  logic       run;

  logic [3:0] pins_meta_reg;
  logic [3:0] pins_sync_reg;
  logic       ms_meta_reg;
  logic       ms_sync_reg;
  logic       ms_prev_reg;
  logic       toggle;

  logic [1:0] state_reg;
  logic [1:0] state_next;
  logic [3:0] last_reg;
  logic [3:0] last_next;
  logic [3:0] cand_reg;
  logic [3:0] cand_next;
  logic [3:0] cnt_reg;
  logic [3:0] cnt_next;
  logic [3:0] color_reg;
  logic [3:0] color_next;
  logic       valid_reg;
  logic       valid_next;
  logic       mode_reg;
  logic       mode_next;
  logic       error_reg;
  logic       error_next;
  logic       accept;
  logic [2:0] onehot;

  // Returns {legal, index}; legal only for exactly one line high.
  function automatic logic [2:0] decode_onehot(input logic [3:0] p);
    logic [2:0] r;
    case (p)
      4'b0001: r = 3'b100;
      4'b0010: r = 3'b101;
      4'b0100: r = 3'b110;
      4'b1000: r = 3'b111;
      default: r = 3'b000;
    endcase
    return r;
  endfunction

  // Reset asserts immediately but releases two edges later, so nothing moves on the release edge.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rst_meta_reg <= 1'b0;
      rst_sync_reg <= 1'b0;
    end else begin
      rst_meta_reg <= 1'b1;
      rst_sync_reg <= rst_meta_reg;
    end
  end

  assign run = rst_sync_reg;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pins_meta_reg <= 4'b0000;
      pins_sync_reg <= 4'b0000;
      ms_meta_reg   <= 1'b0;
      ms_sync_reg   <= 1'b0;
      ms_prev_reg   <= 1'b0;
    end else if (run) begin
      pins_meta_reg <= Pins;
      pins_sync_reg <= pins_meta_reg;
      ms_meta_reg   <= ModeSwitch;
      ms_sync_reg   <= ms_meta_reg;
      ms_prev_reg   <= ms_sync_reg;
    end
  end

  assign toggle = ms_sync_reg & ~ms_prev_reg;

  always_comb begin
    state_next = state_reg;
    last_next  = last_reg;
    cand_next  = cand_reg;
    cnt_next   = cnt_reg;
    color_next = color_reg;
    valid_next = valid_reg;
    mode_next  = mode_reg;
    error_next = 1'b0;
    accept     = 1'b0;
    onehot     = decode_onehot(cand_reg);

    case (state_reg)
      IDLE: begin
        if (pins_sync_reg != last_reg) begin
          cand_next  = pins_sync_reg;
          cnt_next   = 4'd0;
          state_next = SETTLE;
        end
      end
      SETTLE: begin
        if (pins_sync_reg == cand_reg) begin
          if (cnt_reg == ACCEPT_COUNT) begin
            accept = 1'b1;
          end else begin
            cnt_next = cnt_reg + 4'd1;
          end
        end else if (pins_sync_reg == last_reg) begin
          state_next = IDLE;
        end else begin
          cand_next = pins_sync_reg;
          cnt_next  = 4'd0;
        end
      end
      HOLD: begin
        if (Ready) begin
          valid_next = 1'b0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    // A mode toggle on the same edge wins over an accept.
    if (accept && !toggle) begin
      last_next = cand_reg;
      cnt_next  = 4'd0;
      if (mode_reg) begin
        color_next = cand_reg;
        valid_next = 1'b1;
        state_next = HOLD;
      end else if (onehot[2]) begin
        color_next = {2'b00, onehot[1:0]};
        valid_next = 1'b1;
        state_next = HOLD;
      end else begin
        error_next = (cand_reg != 4'b0000);
        state_next = IDLE;
      end
    end

    if (toggle) begin
      mode_next = ~mode_reg;
      last_next = 4'b0000;
      cnt_next  = 4'd0;
      if (state_reg != HOLD) begin
        state_next = IDLE;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg <= IDLE;
      last_reg  <= 4'b0000;
      cand_reg  <= 4'b0000;
      cnt_reg   <= 4'd0;
      color_reg <= 4'b0000;
      valid_reg <= 1'b0;
      mode_reg  <= 1'b0;
      error_reg <= 1'b0;
    end else if (run) begin
      state_reg <= state_next;
      last_reg  <= last_next;
      cand_reg  <= cand_next;
      cnt_reg   <= cnt_next;
      color_reg <= color_next;
      valid_reg <= valid_next;
      mode_reg  <= mode_next;
      error_reg <= error_next;
    end
  end

  assign Color = color_reg;
  assign Valid = valid_reg;
  assign Mode  = mode_reg;
  assign Error = error_reg;

endmodule

// File: tb/tb_color_encoder.sv
// Bench for color_encoder: a table of single-pattern vectors plus hand-written multi-cycle
// sequences (bounce, mode 1 hold, held mode button, reset during hold), scored through a queue.
module tb_color_encoder;

  localparam int SC = 4;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b1;
  logic [3:0] Pins = 4'b0000;
  logic       ModeSwitch = 1'b0;
  logic       Ready = 1'b0;
  logic [3:0] Color;
  logic       Valid;
  logic       Mode;
  logic       Error;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       is_err;
    logic [3:0] color;
  } exp_t;

  typedef struct {
    logic [3:0] pins;
    logic       is_err;
    logic [3:0] color;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[8];

  color_encoder #(.STABLE_CYCLES(SC)) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .Pins      (Pins),
    .ModeSwitch(ModeSwitch),
    .Ready     (Ready),
    .Color     (Color),
    .Valid     (Valid),
    .Mode      (Mode),
    .Error     (Error)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Waits for Valid or Error, then pops the scoreboard and compares.
  task automatic expect_output(input string name, input int budget, output int lat);
    exp_t e;
    lat = 0;
    for (int k = 1; k <= budget; k++) begin
      @(negedge Clk);
      if (Valid || Error) begin
        lat = k;
        break;
      end
    end
    check({name, " seen"}, 32'(Valid | Error), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({name, " error"}, 32'(Error), 32'(e.is_err));
      check({name, " valid"}, 32'(Valid), 32'(!e.is_err));
      check({name, " color"}, 32'(Color), 32'(e.color));
    end
  endtask

  task automatic quiet(input string name, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge Clk);
      if (Valid || Error) seen = 1'b1;
    end
    check({name, " quiet"}, 32'(seen), 32'd0);
  endtask

  task automatic consume();
    tick();
    Ready = 1'b1;
    tick();
    Ready = 1'b0;
  endtask

  task automatic press_mode(input int hold);
    tick();
    ModeSwitch = 1'b1;
    repeat (hold) tick();
    ModeSwitch = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    int   toggles;
    logic ok;
    logic prev_mode;
    logic seen;

    vecs[0] = '{4'b0100, 1'b0, 4'd2};
    vecs[1] = '{4'b0001, 1'b0, 4'd0};
    vecs[2] = '{4'b0010, 1'b0, 4'd1};
    vecs[3] = '{4'b1000, 1'b0, 4'd3};
    vecs[4] = '{4'b0110, 1'b1, 4'd3};
    vecs[5] = '{4'b1111, 1'b1, 4'd3};
    vecs[6] = '{4'b0011, 1'b1, 4'd3};
    vecs[7] = '{4'b0100, 1'b0, 4'd2};

    // Reset state
    #1 Reset_n = 1'b0;
    #2;
    check("reset color", 32'(Color), 32'd0);
    check("reset valid", 32'(Valid), 32'd0);
    check("reset mode", 32'(Mode), 32'd0);
    check("reset error", 32'(Error), 32'd0);
    repeat (3) @(posedge Clk);
    #1 Reset_n = 1'b1;
    quiet("after release", 4);
    check("idle mode", 32'(Mode), 32'd0);

    // Table: mode 0 encode / illegal patterns, Ready held high
    Ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      Pins = vecs[i].pins;
      sb.push_back('{vecs[i].is_err, vecs[i].color});
      expect_output($sformatf("vec%0d pins=%b", i, vecs[i].pins), 30, lat);
      check($sformatf("vec%0d latency", i), 32'(lat), 32'(SC + 3));
      @(negedge Clk);
      check($sformatf("vec%0d one-cycle", i), 32'({Valid, Error}), 32'd0);
      Pins = 4'b0000;
      quiet($sformatf("vec%0d release", i), SC + 6);
    end

    // Bounce shorter than the stable window, then a clean 0001
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge Clk);
      if (Valid || Error) seen = 1'b1;
      Pins = (((c / 2) % 2) == 0) ? 4'b0001 : 4'b0000;
    end
    check("bounce quiet", 32'(seen), 32'd0);
    @(negedge Clk);
    Pins = 4'b0001;
    sb.push_back('{1'b0, 4'b0000});
    expect_output("bounce settle", 20, lat);
    quiet("bounce single valid", SC + 6);
    Pins = 4'b0000;
    quiet("bounce release", SC + 6);

    // Mode 1 pass-through with a long hold and pin activity during hold
    Ready = 1'b0;
    press_mode(3);
    @(negedge Clk);
    check("mode1 entered", 32'(Mode), 32'd1);
    tick();
    Pins = 4'b1011;
    sb.push_back('{1'b0, 4'b1011});
    expect_output("mode1 1011", 20, lat);
    check("mode1 latency", 32'(lat), 32'(SC + 3));
    Pins = 4'b0101;
    ok = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge Clk);
      ok = ok && Valid && (Color == 4'b1011);
    end
    check("mode1 hold stable", 32'(ok), 32'd1);
    sb.push_back('{1'b0, 4'b0101});
    consume();
    @(negedge Clk);
    check("mode1 dropped", 32'(Valid), 32'd0);
    expect_output("mode1 0101", 20, lat);

    // Mode button held: one toggle only, pending code kept
    Pins = 4'b0000;
    toggles = 0;
    prev_mode = Mode;
    tick();
    ModeSwitch = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge Clk);
      if (Mode != prev_mode) toggles++;
      prev_mode = Mode;
    end
    ModeSwitch = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge Clk);
      if (Mode != prev_mode) toggles++;
      prev_mode = Mode;
    end
    check("held button toggles", 32'(toggles), 32'd1);
    check("held button mode", 32'(Mode), 32'd0);
    check("held button valid kept", 32'(Valid), 32'd1);
    check("held button color kept", 32'(Color), 32'b0101);
    consume();
    @(negedge Clk);
    check("held button consumed", 32'(Valid), 32'd0);
    quiet("after consume", SC + 6);

    // Reset during HOLD
    tick();
    Pins = 4'b1000;
    sb.push_back('{1'b0, 4'b0011});
    expect_output("pre-reset hold", 20, lat);
    press_mode(3);
    @(negedge Clk);
    check("hold mode toggled", 32'(Mode), 32'd1);
    check("hold kept over toggle", 32'({Valid, Color}), 32'(5'b10011));
    @(posedge Clk);
    #2 Reset_n = 1'b0;
    #1;
    check("mid reset color", 32'(Color), 32'd0);
    check("mid reset valid", 32'(Valid), 32'd0);
    check("mid reset mode", 32'(Mode), 32'd0);
    repeat (2) @(posedge Clk);
    #1 Reset_n = 1'b1;
    quiet("post reset", 6);
    sb.push_back('{1'b0, 4'b0011});
    expect_output("post reset resettle", 20, lat);

    check("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
